// File: rtl/uart_sb_pkg.sv
// Shared constants for the UART receive FIFO slave: register map,
// STATUS bit layout, configuration reset values and receiver states.
package uart_sb_pkg;

  localparam logic [31:0] ADDR_DATA      = 32'h00;
  localparam logic [31:0] ADDR_STATUS    = 32'h04;
  localparam logic [31:0] ADDR_BUSY      = 32'h08;
  localparam logic [31:0] ADDR_BAUDRATE  = 32'h0C;
  localparam logic [31:0] ADDR_PARITY_EN = 32'h10;
  localparam logic [31:0] ADDR_STOPBIT   = 32'h14;
  localparam logic [31:0] ADDR_IRQ_LEVEL = 32'h18;
  localparam logic [31:0] ADDR_OVF_CLR   = 32'h1C;
  localparam logic [31:0] ADDR_SOFT_RST  = 32'h24;

  localparam int STATUS_NE_BIT    = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_OVF_BIT   = 2;
  localparam int STATUS_COUNT_LSB = 8;

  localparam logic       PARITY_EN_DEFAULT = 1'b1;
  localparam logic       STOPBIT_DEFAULT   = 1'b1;
  localparam logic [8:0] IRQ_LEVEL_DEFAULT = 9'd1;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_STOP2
  } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// UART receive core: 16x oversampling from a fractional baud accumulator,
// 8 data bits LSB first, optional even parity, one or two stop bits.
// valid_o pulses for one cycle in the middle of the first stop bit when the
// frame is good; bad frames are silently dropped.
module uart_rx
  import uart_sb_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        srst_i,
  input  logic [16:0] baud_i,
  input  logic        parity_en_i,
  input  logic        stopbit_i,
  input  logic        rx_i,
  output logic [7:0]  data_o,
  output logic        valid_o,
  output logic        busy_o
);
  localparam logic [31:0] CLK_HZ = 32'(CLK_FREQ);

  rx_state_e   r_state, w_state_next;
  logic [1:0]  r_sync;
  logic [31:0] r_acc, w_sum, w_wrap;
  logic [3:0]  r_tcnt;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_parbit, r_valid;
  logic        w_rx, w_tick, w_last_tick, w_par_ok;

  assign w_rx        = r_sync[1];
  assign w_sum       = r_acc + {11'b0, baud_i, 4'b0};
  assign w_wrap      = w_sum - CLK_HZ;
  assign w_tick      = (w_sum >= CLK_HZ);
  assign w_last_tick = w_tick && (r_tcnt == 4'd15);
  assign w_par_ok    = !parity_en_i || (r_parbit == ^r_shift);
  assign data_o      = r_shift;
  assign valid_o     = r_valid;

  // two-flop synchroniser on the serial line, parked at idle-high
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       r_sync <= 2'b11;
    else if (srst_i) r_sync <= 2'b11;
    else             r_sync <= {r_sync[0], rx_i};
  end

  // fractional accumulator: one tick per 1/16 bit; clamps if baud*16 > clock
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                 r_acc <= '0;
    else if (srst_i)           r_acc <= '0;
    else if (!w_tick)          r_acc <= w_sum;
    else if (w_wrap >= CLK_HZ) r_acc <= '0;
    else                       r_acc <= w_wrap;
  end

  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       r_state <= RX_IDLE;
    else if (srst_i) r_state <= RX_IDLE;
    else             r_state <= w_state_next;
  end

  // frame sequencing; start bit is re-checked at its midpoint to reject glitches
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RX_IDLE:   if (w_tick && !w_rx) w_state_next = RX_START;
      RX_START:  if (w_tick && r_tcnt == 4'd7) w_state_next = w_rx ? RX_IDLE : RX_DATA;
      RX_DATA:   if (w_last_tick && r_bit == 3'd7) w_state_next = parity_en_i ? RX_PARITY : RX_STOP;
      RX_PARITY: if (w_last_tick) w_state_next = RX_STOP;
      RX_STOP:   if (w_last_tick) w_state_next = stopbit_i ? RX_STOP2 : RX_IDLE;
      RX_STOP2:  if (w_last_tick) w_state_next = RX_IDLE;
      default:   w_state_next = RX_IDLE;
    endcase
  end

  // busy covers the whole frame including the optional second stop bit
  always_comb begin
    busy_o = (r_state != RX_IDLE);
  end

  // tick counting and sampling at the middle of each bit
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || srst_i) begin
      r_tcnt   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_parbit <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_tick) begin
        case (r_state)
          RX_IDLE: begin
            r_tcnt <= '0;
            r_bit  <= '0;
          end
          RX_START: r_tcnt <= (r_tcnt == 4'd7) ? 4'd0 : r_tcnt + 4'd1;
          default: begin
            r_tcnt <= r_tcnt + 4'd1;
            if (r_tcnt == 4'd15) begin
              if (r_state == RX_DATA) begin
                r_shift <= {w_rx, r_shift[7:1]};
                r_bit   <= r_bit + 3'd1;
              end
              if (r_state == RX_PARITY) r_parbit <= w_rx;
              if (r_state == RX_STOP)   r_valid  <= w_rx && w_par_ok;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Byte FIFO for received characters. Pointers wrap modulo DEPTH, count is
// one bit wider so that "full" is representable. A pop on an empty FIFO
// is ignored; a push while full only lands if a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  output logic [7:0]               data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push, w_pop;

  assign full_o  = (r_count == FULL_CNT);
  assign empty_o = (r_count == '0);
  assign w_pop   = pop_i && !empty_o;
  assign w_push  = push_i && (!full_o || w_pop);
  assign data_o  = r_mem[r_rd_ptr];
  assign count_o = r_count;

  // storage array, left without reset so it can map onto RAM
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

  // pointer and occupancy bookkeeping; flush empties the FIFO in one edge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

endmodule

// File: rtl/uart_rx_fifo_sb_ctrl.sv
// Bus slave wrapping the UART receive core and its FIFO: register file,
// sticky overflow, level interrupt with return-mask, and soft reset.
module uart_rx_fifo_sb_ctrl #(
  parameter int FIFO_DEPTH   = 16,
  parameter int BAUD_DEFAULT = 9600,
  parameter int CLK_FREQ     = 50_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic        write_enable_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] read_data_o,
  output logic        interrupt_request_o,
  input  logic        interrupt_return_i,
  input  logic        rx_i
);
  import uart_sb_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [16:0]   r_baud;
  logic          r_parity_en, r_stopbit, r_ovf, r_mask, r_core_srst;
  logic [8:0]    r_irq_level;
  logic [31:0]   r_read_data, w_rdata, w_status;
  logic          w_rd, w_wr, w_pop, w_soft, w_ovf_evt;
  logic          w_rx_valid, w_busy, w_full, w_empty;
  logic [7:0]    w_rx_data, w_head;
  logic [CW-1:0] w_count;
  logic          w_unused_wdata;

  assign w_rd      = req_i && !write_enable_i;
  assign w_wr      = req_i && write_enable_i;
  assign w_pop     = w_rd && (addr_i == ADDR_DATA) && !w_empty;
  assign w_soft    = w_wr && (addr_i == ADDR_SOFT_RST);
  assign w_ovf_evt = w_rx_valid && w_full && !w_pop;
  assign w_unused_wdata = ^write_data_i[31:17];
  assign read_data_o = r_read_data;
  assign interrupt_request_o = !r_mask &&
      (((r_irq_level != 9'd0) && (9'(w_count) >= r_irq_level)) || r_ovf);

  uart_rx #(.CLK_FREQ(CLK_FREQ)) u_core (
    .clk_i(clk_i), .rst_i(rst_i), .srst_i(r_core_srst),
    .baud_i(r_baud), .parity_en_i(r_parity_en), .stopbit_i(r_stopbit),
    .rx_i(rx_i), .data_o(w_rx_data), .valid_o(w_rx_valid), .busy_o(w_busy)
  );

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(w_soft),
    .push_i(w_rx_valid), .data_i(w_rx_data), .pop_i(w_pop),
    .data_o(w_head), .full_o(w_full), .empty_o(w_empty), .count_o(w_count)
  );

  // STATUS word assembled from FIFO state and the sticky overflow flag
  always_comb begin
    w_status = '0;
    w_status[STATUS_COUNT_LSB +: CW] = w_count;
    w_status[STATUS_OVF_BIT]         = r_ovf;
    w_status[STATUS_FULL_BIT]        = w_full;
    w_status[STATUS_NE_BIT]          = !w_empty;
  end

  // read multiplexer; write-only and unmapped addresses read as zero
  always_comb begin
    w_rdata = '0;
    case (addr_i)
      ADDR_DATA:      w_rdata = {24'b0, w_empty ? 8'h00 : w_head};
      ADDR_STATUS:    w_rdata = w_status;
      ADDR_BUSY:      w_rdata = {31'b0, w_busy};
      ADDR_BAUDRATE:  w_rdata = {15'b0, r_baud};
      ADDR_PARITY_EN: w_rdata = {31'b0, r_parity_en};
      ADDR_STOPBIT:   w_rdata = {31'b0, r_stopbit};
      ADDR_IRQ_LEVEL: w_rdata = {23'b0, r_irq_level};
      default:        w_rdata = '0;
    endcase
  end

  // registered read port, holds its value between reads
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     r_read_data <= '0;
    else if (w_rd) r_read_data <= w_rdata;
  end

  // configuration registers; line format is frozen while a frame is in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || w_soft) begin
      r_baud      <= 17'(BAUD_DEFAULT);
      r_parity_en <= PARITY_EN_DEFAULT;
      r_stopbit   <= STOPBIT_DEFAULT;
      r_irq_level <= IRQ_LEVEL_DEFAULT;
    end else if (w_wr) begin
      if (!w_busy) begin
        case (addr_i)
          ADDR_BAUDRATE:  r_baud      <= write_data_i[16:0];
          ADDR_PARITY_EN: r_parity_en <= write_data_i[0];
          ADDR_STOPBIT:   r_stopbit   <= write_data_i[0];
          default: ;
        endcase
      end
      if (addr_i == ADDR_IRQ_LEVEL) r_irq_level <= write_data_i[8:0];
    end
  end

  // sticky overflow; a new overflow beats a same-cycle clear
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                r_ovf <= 1'b0;
    else if (w_soft)                          r_ovf <= 1'b0;
    else if (w_ovf_evt)                       r_ovf <= 1'b1;
    else if (w_wr && addr_i == ADDR_OVF_CLR)  r_ovf <= 1'b0;
  end

  // interrupt mask: set by return strobe, dropped by any new received byte
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                   r_mask <= 1'b0;
    else if (w_soft)             r_mask <= 1'b0;
    else if (w_rx_valid)         r_mask <= 1'b0;
    else if (interrupt_return_i) r_mask <= 1'b1;
  end

  // core held in reset for the single cycle after a soft-reset write
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_core_srst <= 1'b0;
    else       r_core_srst <= w_soft;
  end

endmodule

// File: tb/tb_uart_rx_fifo_sb_ctrl.sv
// Bench for uart_rx_fifo_sb_ctrl: drives serial frames and bus cycles,
// tracks expected behaviour with a queue-based model, and compares the
// read port and interrupt against it on every falling clock edge.
module tb_uart_rx_fifo_sb_ctrl;
  import uart_sb_pkg::*;

  localparam int DEPTH = 16;
  localparam int CLKF  = 307200;   // 9600 baud * 16 oversample * 2 clocks
  localparam int BIT   = 32;       // clocks per bit at 9600 baud

  logic        clk = 1'b0, rst_i = 1'b1, req_i = 1'b0, we = 1'b0;
  logic        irq_ret = 1'b0, rx = 1'b1;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic        irq;

  always #5 clk = ~clk;

  uart_rx_fifo_sb_ctrl #(.FIFO_DEPTH(DEPTH), .BAUD_DEFAULT(9600), .CLK_FREQ(CLKF)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .addr_i(addr),
    .write_enable_i(we), .write_data_i(wdata), .read_data_o(rdata),
    .interrupt_request_o(irq), .interrupt_return_i(irq_ret), .rx_i(rx)
  );

  int n_cmp = 0, n_bad = 0;

  // behavioural model
  logic [7:0]  mq[$];
  logic        m_ovf = 0, m_mask = 0, m_busy = 0, m_par = 1, m_stop = 1, quiet = 1;
  logic [16:0] m_baud = 17'd9600;
  logic [8:0]  m_lvl = 9'd1;
  logic [31:0] m_rd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_irq();
    return !m_mask && ((m_lvl != 0 && mq.size() >= int'(m_lvl)) || m_ovf);
  endfunction

  function automatic logic [31:0] model_status();
    int n = mq.size();
    return (32'(n) << 8) | (m_ovf ? 32'h4 : 32'h0) | (n == DEPTH ? 32'h2 : 32'h0)
           | (n != 0 ? 32'h1 : 32'h0);
  endfunction

  function automatic void model_defaults();
    m_baud = 17'd9600; m_par = 1; m_stop = 1; m_lvl = 9'd1;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [7:0] b;
    case (a)
      ADDR_DATA: begin
        if (mq.size() == 0) return 32'h0;
        b = mq.pop_front();
        return {24'h0, b};
      end
      ADDR_STATUS:    return model_status();
      ADDR_BUSY:      return {31'h0, m_busy};
      ADDR_BAUDRATE:  return {15'h0, m_baud};
      ADDR_PARITY_EN: return {31'h0, m_par};
      ADDR_STOPBIT:   return {31'h0, m_stop};
      ADDR_IRQ_LEVEL: return {23'h0, m_lvl};
      default:        return 32'h0;
    endcase
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d);
    case (a)
      ADDR_BAUDRATE:  if (!m_busy) m_baud = d[16:0];
      ADDR_PARITY_EN: if (!m_busy) m_par = d[0];
      ADDR_STOPBIT:   if (!m_busy) m_stop = d[0];
      ADDR_IRQ_LEVEL: m_lvl = d[8:0];
      ADDR_OVF_CLR:   m_ovf = 0;
      ADDR_SOFT_RST: begin mq.delete(); m_ovf = 0; m_mask = 0; model_defaults(); end
      default: ;
    endcase
  endfunction

  function automatic void model_push(input logic [7:0] b);
    if (mq.size() < DEPTH) mq.push_back(b);
    else m_ovf = 1;
    m_mask = 0;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] got);
    req_i = 1; we = 0; addr = a;
    @(posedge clk); #1;
    req_i = 0;
    m_rd = model_read(a);
    got = rdata;
    $display("read  addr=0x%02h data=0x%08h", a, rdata);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    req_i = 1; we = 1; addr = a; wdata = d;
    @(posedge clk); #1;
    req_i = 0; we = 0;
    model_write(a, d);
    $display("write addr=0x%02h data=0x%08h", a, d);
  endtask

  task automatic irq_return();
    irq_ret = 1;
    @(posedge clk); #1;
    irq_ret = 0;
    m_mask = 1;
    $display("irq return");
  endtask

  task automatic send_frame(input logic [7:0] b);
    quiet = 0;
    rx = 0; cyc(BIT/2); m_busy = 1; cyc(BIT/2);
    for (int i = 0; i < 8; i++) begin rx = b[i]; cyc(BIT); end
    if (m_par) begin rx = ^b; cyc(BIT); end
    rx = 1; cyc(BIT);
    if (m_stop) cyc(BIT);
    m_busy = 0;
    cyc(BIT/2);
    model_push(b);
    quiet = 1;
    $display("frame 0x%02h sent", b);
  endtask

  // continuous comparison of the read port and the interrupt line
  always @(negedge clk) begin
    if (!rst_i) begin
      check("rdata", rdata, m_rd);
      if (quiet) check("irq", {31'h0, irq}, {31'h0, model_irq()});
    end
  end

  logic [31:0] got;

  initial begin
    // reset state
    cyc(2);
    check("rst_rdata", rdata, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    rst_i = 0;
    cyc(4);

    // single byte with parity at default baud
    send_frame(8'hA5);
    bus_read(ADDR_STATUS, got); check("a5_status", got, 32'h0101);
    check("a5_irq", {31'h0, irq}, 32'h1);
    bus_read(ADDR_DATA, got);   check("a5_data", got, 32'hA5);
    bus_read(ADDR_STATUS, got); check("a5_status_after", got, 32'h0);
    bus_read(ADDR_DATA, got);   check("empty_data", got, 32'h0);
    bus_read(32'h20, got);      check("unmapped", got, 32'h0);

    // interrupt threshold
    bus_write(ADDR_IRQ_LEVEL, 32'd4);
    for (int i = 0; i < 3; i++) send_frame(8'(8'h21 + i));
    check("lvl_irq3", {31'h0, irq}, 32'h0);
    send_frame(8'h24);
    check("lvl_irq4", {31'h0, irq}, 32'h1);
    bus_read(ADDR_DATA, got);   check("lvl_pop", got, 32'h21);
    check("lvl_irq_after_pop", {31'h0, irq}, 32'h0);
    for (int i = 0; i < 3; i++) bus_read(ADDR_DATA, got);
    bus_write(ADDR_IRQ_LEVEL, 32'd1);

    // interrupt return mask until next byte
    send_frame(8'h77);
    irq_return();
    check("mask_irq", {31'h0, irq}, 32'h0);
    send_frame(8'h78);
    check("unmask_irq", {31'h0, irq}, 32'h1);
    bus_read(ADDR_DATA, got); bus_read(ADDR_DATA, got);

    // overflow: 17 bytes into 16 entries
    for (int i = 0; i < 17; i++) send_frame(8'(8'h10 + i));
    bus_read(ADDR_STATUS, got); check("ovf_status", got, 32'h1007);
    check("ovf_irq", {31'h0, irq}, 32'h1);
    for (int i = 0; i < 16; i++) begin
      bus_read(ADDR_DATA, got); check("ovf_drain", got, 32'(8'h10 + i));
    end
    bus_read(ADDR_STATUS, got); check("ovf_sticky", got, 32'h0004);
    bus_write(ADDR_OVF_CLR, 32'h0);
    bus_read(ADDR_STATUS, got); check("ovf_cleared", got, 32'h0);

    // pop coincident with push while full
    for (int i = 0; i < 16; i++) send_frame(8'(8'h40 + i));
    bus_read(ADDR_STATUS, got); check("full_status", got, 32'h1003);
    fork
      send_frame(8'h99);
      begin
        int k = 0;
        while (dut.w_rx_valid !== 1'b1 && k < 20 * BIT) begin @(negedge clk); k++; end
        check("coincident_seen", {31'h0, k < 20 * BIT}, 32'h1);
        req_i = 1; we = 0; addr = ADDR_DATA;
        @(posedge clk); #1;
        req_i = 0;
        m_rd = model_read(ADDR_DATA);
        check("coincident_pop", rdata, 32'h40);
      end
    join
    bus_read(ADDR_STATUS, got); check("coincident_status", got, 32'h1003);
    for (int i = 1; i < 16; i++) begin
      bus_read(ADDR_DATA, got); check("coincident_order", got, 32'(8'h40 + i));
    end
    bus_read(ADDR_DATA, got); check("coincident_last", got, 32'h99);

    // config writes ignored mid-frame; soft reset restores defaults
    fork
      send_frame(8'h3C);
      begin
        cyc(BIT * 4);
        bus_read(ADDR_BUSY, got); check("busy_mid", got, 32'h1);
        bus_write(ADDR_BAUDRATE, 32'd115200);
      end
    join
    bus_read(ADDR_BAUDRATE, got);  check("baud_ignored", got, 32'd9600);
    bus_write(ADDR_BAUDRATE, 32'd19200);
    bus_write(ADDR_PARITY_EN, 32'd0);
    bus_write(ADDR_STOPBIT, 32'd0);
    bus_write(ADDR_IRQ_LEVEL, 32'd5);
    bus_read(ADDR_BAUDRATE, got);  check("baud_set", got, 32'd19200);
    bus_read(ADDR_PARITY_EN, got); check("par_set", got, 32'd0);
    bus_write(ADDR_SOFT_RST, 32'h0);
    bus_read(ADDR_BAUDRATE, got);  check("srst_baud", got, 32'd9600);
    bus_read(ADDR_PARITY_EN, got); check("srst_par", got, 32'd1);
    bus_read(ADDR_STOPBIT, got);   check("srst_stop", got, 32'd1);
    bus_read(ADDR_IRQ_LEVEL, got); check("srst_lvl", got, 32'd1);
    bus_read(ADDR_STATUS, got);    check("srst_status", got, 32'h0);

    // asynchronous reset in the middle of a frame
    send_frame(8'h5A);
    bus_read(ADDR_STATUS, got); check("pre_rst_status", got, 32'h0101);
    quiet = 0;
    rx = 0;
    cyc(BIT * 3);
    #2;
    rst_i = 1; rx = 1;
    mq.delete(); m_ovf = 0; m_mask = 0; m_busy = 0; m_rd = '0; model_defaults();
    #1;
    check("arst_rdata", rdata, 32'h0);
    check("arst_irq", {31'h0, irq}, 32'h0);
    cyc(3);
    rst_i = 0;
    cyc(BIT * 12);
    quiet = 1;
    bus_read(ADDR_STATUS, got); check("arst_no_push", got, 32'h0);

    // randomized traffic against the model
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 10))
        0, 1, 2, 3: send_frame(8'($urandom_range(0, 255)));
        4, 5:       bus_read(ADDR_DATA, got);
        6:          bus_read(ADDR_STATUS, got);
        7:          irq_return();
        8:          bus_write(ADDR_OVF_CLR, $urandom);
        9:          bus_write(ADDR_IRQ_LEVEL, 32'($urandom_range(0, 18)));
        default: begin
          bus_write(ADDR_PARITY_EN, 32'($urandom_range(0, 1)));
          bus_write(ADDR_STOPBIT, 32'($urandom_range(0, 1)));
        end
      endcase
    end
    while (mq.size() > 0) bus_read(ADDR_DATA, got);
    bus_read(ADDR_DATA, got); check("final_empty", got, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
